mfhwt_linebuf_ctrl: RTL and testbench
=====================================

Name: mfhwt_linebuf_ctrl

Overview:
- Sequencer for the 4-line, 16-bit pixel FIFO buffer of the MFHWT front end.
- Accepts a raster pixel stream and steers each image line into FIFO 0..3 in rotation.
- Once four lines are buffered, drains all four FIFOs in lockstep as 64-bit four-row columns for the Haar wavelet stage.
- Stalls the upstream source while draining and flags protocol faults.

Parameters:
- LINE_W, 640, pixels per line and per FIFO (depth of each line FIFO).
- FRAME_H, 480, lines per frame; must be a multiple of 4.
- CW, 10, column counter width; requires 2^CW >= LINE_W.
- RW, 9, line counter width; requires 2^RW >= FRAME_H.

Ports:
- iClk  in  1  system clock, all logic rising-edge.
- iRst_n  in  1  asynchronous active-low reset.
- iValid  in  1  upstream pixel valid.
- iData  in  16  upstream pixel.
- oReady  out  1  controller can accept a pixel this cycle.
- oWrreq  out  4  one-hot write request to line FIFOs 3..0.
- oFifoData  out  16  pixel to FIFO demux, registered copy of iData.
- oRdreq  out  1  common read request to all four FIFOs.
- iFull  in  4  full flags from FIFOs 3..0.
- iEmpty  in  1  AND of the four FIFO empty flags.
- oColValid  out  1  four-row column valid on the FIFO q bus (q is consumed directly by downstream).
- oColIdx  out  CW  column index of the current valid column.
- oLineGrp  out  RW-2  index of the 4-line group being drained.
- oFrameDone  out  1  single-cycle pulse after the last column of the frame.
- oErr  out  1  sticky fault flag.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all counters 0, oReady=0. oWrreq, oRdreq, oColValid, oColIdx, oLineGrp, oFrameDone, oErr, oFifoData all 0.
- Accept rule: a pixel is accepted when iValid && oReady.
- IDLE:
  - oReady=1.
  - First accepted pixel moves to FILL with line=0, col=0.
  - That pixel is written like any FILL pixel.
- FILL:
  - oReady=1.
  - Accepted pixel: next cycle oFifoData=pixel and oWrreq=onehot(line[1:0]). One-cycle write latency; no write on cycles without an accept.
  - col increments per accept. At col==LINE_W-1, col wraps to 0 and line increments.
  - When the accept of pixel (LINE_W-1) of line[1:0]==3 occurs, oReady drops the next cycle; the registered write still issues. State then goes to WAIT1 for one cycle, so the last write lands before reading.
- WAIT1: oReady=0; moves to DRAIN.
- DRAIN:
  - oReady=0; oRdreq=1 for exactly LINE_W consecutive cycles, rd counter 0..LINE_W-1.
  - FIFO q valid one cycle after rdreq: oColValid=oRdreq delayed 1, oColIdx=rd counter delayed 1, oLineGrp=line[RW-1:2] of the group being drained.
  - After the last rdreq, goes to WAIT2.
- WAIT2:
  - Last column valid this cycle.
  - If line==FRAME_H (frame complete): oFrameDone=1 this cycle, line clears to 0, state=IDLE.
  - Otherwise: state=FILL, oReady=1 next cycle.
- Faults, all set oErr sticky until reset:
  - Write issued while the target iFull bit is 1: write still issued.
  - iEmpty=1 while oRdreq=1: read still issued.
  - iEmpty=0 on entry to FILL at line[1:0]==0: stale data.
- iValid while oReady=0 is ignored, not queued; upstream must hold the pixel.
- Reset mid-operation: all state clears immediately. FIFO contents are not flushed by this block; the system resets the FIFOs with the same reset.
- Counter widths: col/rd wrap at LINE_W (not 2^CW); line counts to FRAME_H inclusive.

Test Plan:
- Reset then idle: hold iRst_n=0 with iValid=1 -> all outputs 0; release -> oReady=1 next cycle, no oWrreq until the first accept.
- Continuous fill, LINE_W=640: 2560 back-to-back pixels (value=index) -> oWrreq=0001 for pixels 0-639, 0010 for 640-1279, 0100, 1000. oFifoData lags iData by 1. oReady=0 from the cycle after pixel 2559.
- Drain timing: after the fill above -> oRdreq high 640 cycles, oColValid high 640 cycles delayed by 1, oColIdx 0..639, oLineGrp=0. oReady returns 1 the cycle after the last oColValid.
- Backpressure and gaps: random iValid gaps during fill; iValid held high during DRAIN -> no pixels lost or duplicated; FIFO write count equals accept count exactly.
- Frame end, FRAME_H=8, LINE_W=4 -> two fill/drain groups; oLineGrp 0 then 1; oFrameDone one pulse coinciding with the last oColValid (colidx 3); state returns to IDLE.
- Faults: force iFull[2]=1 during line-2 writes -> oErr=1 and stays 1. Force iEmpty=1 mid-drain -> oErr=1. Async reset mid-DRAIN -> oRdreq=0 immediately, oErr cleared.

Source files
------------

// File: rtl/mfhwt_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mfhwt_linebuf_ctrl
// Brief    : Four-line pixel FIFO sequencer for the MFHWT front end. Steers
//            raster lines into line FIFOs 0..3 in rotation. When four lines
//            are held, it drains them in lockstep as four-row columns. It also
//            stalls the source while draining and records protocol faults.
// Revision : 1.0 - initial release
// ============================================================================
module mfhwt_linebuf_ctrl #(
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480,
  parameter int CW      = 10,
  parameter int RW      = 9
) (
  input  logic          iClk,
  input  logic          iRst_n,
  input  logic          iValid,
  input  logic [15:0]   iData,
  output logic          oReady,
  output logic [3:0]    oWrreq,
  output logic [15:0]   oFifoData,
  output logic          oRdreq,
  input  logic [3:0]    iFull,
  input  logic          iEmpty,
  output logic          oColValid,
  output logic [CW-1:0] oColIdx,
  output logic [RW-3:0] oLineGrp,
  output logic          oFrameDone,
  output logic          oErr
);

  localparam logic [CW-1:0] c_LAST_COL = CW'(LINE_W - 1);
  localparam logic [RW-1:0] c_FRAME_H  = RW'(FRAME_H);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_WAIT1 = 3'd2,
    S_DRAIN = 3'd3,
    S_WAIT2 = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [CW-1:0] r_col;
  logic [CW-1:0] r_rd;
  logic [RW-1:0] r_line;
  logic [RW-3:0] r_grp;
  logic          r_ready;
  logic [3:0]    r_wrreq;
  logic [15:0]   r_fifodata;
  logic          r_colvalid;
  logic [CW-1:0] r_colidx;
  logic [RW-3:0] r_linegrp;
  logic          r_err;

  logic          w_accept;
  logic          w_grp_last;
  logic          w_rd_last;
  logic          w_frame_end;
  logic          w_rdreq;
  logic          w_done;
  logic          w_fill_entry;
  logic          w_fault;
  logic          w_ready_next;

  assign w_accept     = iValid & r_ready;
  // The last pixel of the fourth line in a group closes the fill phase.
  assign w_grp_last   = w_accept & (r_col == c_LAST_COL) & (r_line[1:0] == 2'd3);
  assign w_rd_last    = (r_rd == c_LAST_COL);
  assign w_frame_end  = (r_line == c_FRAME_H);
  // FILL is entered only at a group boundary. At that point every FIFO must be empty.
  assign w_fill_entry = (w_next == S_FILL) & (r_state != S_FILL) & (r_line[1:0] == 2'd0);
  assign w_fault      = (|(r_wrreq & iFull)) | (w_rdreq & iEmpty) | (w_fill_entry & ~iEmpty);
  assign w_ready_next = (w_next == S_IDLE) | (w_next == S_FILL);

  // State register.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic plus the outputs decoded directly from the state.
  always_comb begin
    w_next  = r_state;
    w_rdreq = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_grp_last ? S_WAIT1 : S_FILL;
      end
      S_FILL: begin
        if (w_grp_last) w_next = S_WAIT1;
      end
      // One idle cycle lets the final registered write land before reading.
      S_WAIT1: w_next = S_DRAIN;
      S_DRAIN: begin
        w_rdreq = 1'b1;
        if (w_rd_last) w_next = S_WAIT2;
      end
      S_WAIT2: begin
        if (w_frame_end) begin
          w_done = 1'b1;
          w_next = S_IDLE;
        end else begin
          w_next = S_FILL;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Fill-side column and line counters. The group index is latched for the drain.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_col  <= '0;
      r_line <= '0;
      r_grp  <= '0;
    end else if (w_accept) begin
      r_grp <= r_line[RW-1:2];
      if (r_col == c_LAST_COL) begin
        r_col  <= '0;
        r_line <= r_line + RW'(1);
      end else begin
        r_col  <= r_col + CW'(1);
      end
    end else if (w_done) begin
      r_line <= '0;
    end
  end

  // Registered write path: one-hot FIFO select plus a pixel copy, one cycle after accept.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_wrreq    <= 4'b0000;
      r_fifodata <= 16'h0000;
    end else begin
      r_wrreq <= w_accept ? (4'b0001 << r_line[1:0]) : 4'b0000;
      if (w_accept) r_fifodata <= iData;
    end
  end

  // Drain read counter. Column-valid is aligned to the FIFO q, one cycle after rdreq.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_rd       <= '0;
      r_colvalid <= 1'b0;
      r_colidx   <= '0;
      r_linegrp  <= '0;
    end else begin
      r_colvalid <= w_rdreq;
      if (w_rdreq) begin
        r_rd      <= w_rd_last ? '0 : r_rd + CW'(1);
        r_colidx  <= r_rd;
        r_linegrp <= r_grp;
      end
    end
  end

  // Ready is registered so that it reads low during reset and rises on the first clock after release.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= w_ready_next;
      r_err   <= r_err | w_fault;
    end
  end

  assign oReady     = r_ready;
  assign oWrreq     = r_wrreq;
  assign oFifoData  = r_fifodata;
  assign oRdreq     = w_rdreq;
  assign oColValid  = r_colvalid;
  assign oColIdx    = r_colidx;
  assign oLineGrp   = r_linegrp;
  assign oFrameDone = w_done;
  assign oErr       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mfhwt_linebuf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfhwt_linebuf_ctrl
// Brief    : Directed testbench for mfhwt_linebuf_ctrl, using small geometry
//            (LINE_W=4, FRAME_H=8). A vector table covers one whole frame;
//            hand-written sequences cover reset and the fault cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfhwt_linebuf_ctrl;

  localparam int LINE_W  = 4;
  localparam int FRAME_H = 8;
  localparam int CW      = 3;
  localparam int RW      = 4;

  logic          clk;
  logic          rst_n;
  logic          iValid;
  logic [15:0]   iData;
  logic [3:0]    iFull;
  logic          iEmpty;
  logic          oReady;
  logic [3:0]    oWrreq;
  logic [15:0]   oFifoData;
  logic          oRdreq;
  logic          oColValid;
  logic [CW-1:0] oColIdx;
  logic [RW-3:0] oLineGrp;
  logic          oFrameDone;
  logic          oErr;

  int n_vec  = 0;
  int n_fail = 0;

  mfhwt_linebuf_ctrl #(
    .LINE_W(LINE_W), .FRAME_H(FRAME_H), .CW(CW), .RW(RW)
  ) u_dut (
    .iClk(clk), .iRst_n(rst_n), .iValid(iValid), .iData(iData),
    .oReady(oReady), .oWrreq(oWrreq), .oFifoData(oFifoData), .oRdreq(oRdreq),
    .iFull(iFull), .iEmpty(iEmpty), .oColValid(oColValid), .oColIdx(oColIdx),
    .oLineGrp(oLineGrp), .oFrameDone(oFrameDone), .oErr(oErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        empty;
    logic        e_ready;
    logic [3:0]  e_wr;
    logic        e_rd;
    logic        e_cv;
    logic [2:0]  e_ci;
    logic [1:0]  e_lg;
    logic        e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic empty,
                              input logic rdy, input logic [3:0] wr, input logic rd,
                              input logic cv, input logic [2:0] ci, input logic [1:0] lg,
                              input logic done);
    vec_t r;
    r.v = v; r.d = d; r.empty = empty; r.e_ready = rdy; r.e_wr = wr; r.e_rd = rd;
    r.e_cv = cv; r.e_ci = ci; r.e_lg = lg; r.e_done = done;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each call presents n back-to-back pixels. Pixel values count up from base.
  task automatic feed(input int n, input logic [15:0] base, input logic [3:0] full);
    for (int i = 0; i < n; i++) begin
      iValid = 1'b1;
      iData  = base + 16'(i);
      iFull  = full;
      iEmpty = 1'b1;
      tick();
    end
    iValid = 1'b0;
    iFull  = 4'b0000;
  endtask

  task automatic reset_release();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n_wr;
    int   n_acc;
    logic prev_ready;

    // Build one whole frame: two groups. The second group has input gaps.
    for (int g = 0; g < 2; g++) begin
      for (int p = 0; p < 16; p++) begin
        if (g == 1 && (p % 3) == 1)
          tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
        tbl.push_back(mk(1'b1, 16'(256 * (g + 1) + p), 1'b1, (p != 15),
                         4'(1 << (p / 4)), 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
      end
      // WAIT1: valid is held high but must be ignored.
      tbl.push_back(mk(1'b1, 16'hDEAD, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0));
      for (int c = 0; c < 4; c++)
        tbl.push_back(mk(1'b1, 16'hBEEF, 1'b0, 1'b0, 4'b0000, (c != 3), 1'b1,
                         3'(c), 2'(g), (c == 3) && (g == 1)));
      // WAIT2 cycle. FIFOs are empty again.
      tbl.push_back(mk(1'b0, 16'h0, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0));
    end

    // Reset with valid held high: every output must stay at zero.
    rst_n = 1'b0; iValid = 1'b1; iData = 16'hAAAA; iFull = 4'b0000; iEmpty = 1'b1;
    tick(); tick();
    chk("rst oReady",     32'(oReady), 0);
    chk("rst oWrreq",     32'(oWrreq), 0);
    chk("rst oFifoData",  32'(oFifoData), 0);
    chk("rst oRdreq",     32'(oRdreq), 0);
    chk("rst oColValid",  32'(oColValid), 0);
    chk("rst oColIdx",    32'(oColIdx), 0);
    chk("rst oLineGrp",   32'(oLineGrp), 0);
    chk("rst oFrameDone", 32'(oFrameDone), 0);
    chk("rst oErr",       32'(oErr), 0);
    reset_release();
    chk("rel oReady", 32'(oReady), 1);
    chk("rel oWrreq", 32'(oWrreq), 0);

    // Apply the frame table.
    n_wr = 0; n_acc = 0; prev_ready = 1'b1;
    foreach (tbl[i]) begin
      iValid = tbl[i].v; iData = tbl[i].d; iEmpty = tbl[i].empty; iFull = 4'b0000;
      if (tbl[i].v && prev_ready) n_acc++;
      prev_ready = tbl[i].e_ready;
      tick();
      if (oWrreq != 4'b0000) n_wr++;
      chk($sformatf("v%0d oReady", i),     32'(oReady),     32'(tbl[i].e_ready));
      chk($sformatf("v%0d oWrreq", i),     32'(oWrreq),     32'(tbl[i].e_wr));
      chk($sformatf("v%0d oRdreq", i),     32'(oRdreq),     32'(tbl[i].e_rd));
      chk($sformatf("v%0d oColValid", i),  32'(oColValid),  32'(tbl[i].e_cv));
      chk($sformatf("v%0d oFrameDone", i), 32'(oFrameDone), 32'(tbl[i].e_done));
      chk($sformatf("v%0d oErr", i),       32'(oErr),       0);
      if (tbl[i].e_wr != 4'b0000)
        chk($sformatf("v%0d oFifoData", i), 32'(oFifoData), 32'(tbl[i].d));
      if (tbl[i].e_cv) begin
        chk($sformatf("v%0d oColIdx", i),  32'(oColIdx),  32'(tbl[i].e_ci));
        chk($sformatf("v%0d oLineGrp", i), 32'(oLineGrp), 32'(tbl[i].e_lg));
      end
    end
    iValid = 1'b0;
    chk("write count", 32'(n_wr), 32'(n_acc));
    chk("accept count", 32'(n_acc), 32);

    // Full-flag fault: FIFO 2 reports full during the line-2 writes.
    feed(8, 16'h2000, 4'b0100);
    chk("full lines0-1 oErr", 32'(oErr), 0);
    feed(1, 16'h2008, 4'b0100);
    chk("full pre-write oErr", 32'(oErr), 0);
    feed(1, 16'h2009, 4'b0100);
    chk("full set oErr", 32'(oErr), 1);
    feed(6, 16'h200A, 4'b0000);
    chk("full sticky oErr", 32'(oErr), 1);

    // Asynchronous reset in the middle of DRAIN.
    iEmpty = 1'b0;
    tick();
    chk("drain oRdreq", 32'(oRdreq), 1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst oRdreq", 32'(oRdreq), 0);
    chk("async rst oErr",   32'(oErr), 0);
    chk("async rst oReady", 32'(oReady), 0);
    tick();
    iEmpty = 1'b1;
    reset_release();

    // Stale-data fault: FIFOs are not empty when the first line starts.
    iEmpty = 1'b0; iValid = 1'b1; iData = 16'h3000;
    tick();
    chk("stale entry oErr", 32'(oErr), 1);
    iValid = 1'b0; iEmpty = 1'b1; rst_n = 1'b0;
    tick();
    reset_release();

    // Empty flag asserted mid-drain. Valid is held high throughout.
    feed(16, 16'h4000, 4'b0000);
    iValid = 1'b1; iData = 16'h5555; iEmpty = 1'b0;
    tick();
    tick();
    chk("empty pre oErr", 32'(oErr), 0);
    iEmpty = 1'b1;
    tick();
    chk("empty set oErr", 32'(oErr), 1);
    iEmpty = 1'b0;
    tick(); tick();
    chk("empty last col", 32'(oColValid), 1);
    tick();
    chk("empty sticky oErr", 32'(oErr), 1);
    chk("refill oReady", 32'(oReady), 1);
    iValid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
